// File: rtl/full_adder_unit.sv
// rtl/full_adder_unit.sv - ripple-carry adder built from 1-bit full-adder cells, with combinational and registered results

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_r,
  output logic             Cout_r,
  output logic             Ovf_r,
  output logic             valid_r
);

  // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out
  logic [WIDTH:0] carry;
  logic           ovf;

  assign carry[0] = Cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
        .a  (A[i]),
        .b  (B[i]),
        .c  (carry[i]),
        .s  (Sum[i]),
        .co (carry[i+1])
      );
    end
  endgenerate

  assign Cout = carry[WIDTH];
  // Two's-complement overflow: carry into the sign bit differs from carry out of it
  assign ovf  = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum_r   <= '0;
      Cout_r  <= 1'b0;
      Ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      Sum_r   <= Sum;
      Cout_r  <= Cout;
      Ovf_r   <= ovf;
      valid_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// tb/tb_full_adder_unit.sv - directed and random checks of full_adder_unit at WIDTH=1 and WIDTH=8

module tb_full_adder_unit;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, cin1;
  logic       sum1, cout1, sum1_r, cout1_r, ovf1_r, valid1_r;

  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8, sum8_r;
  logic       cout8, cout8_r, ovf8_r, valid8_r;

  int n_checks;
  int n_fail;

  full_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (a1),
    .B       (b1),
    .Cin     (cin1),
    .Sum     (sum1),
    .Cout    (cout1),
    .Sum_r   (sum1_r),
    .Cout_r  (cout1_r),
    .Ovf_r   (ovf1_r),
    .valid_r (valid1_r)
  );

  full_adder_unit #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (a8),
    .B       (b8),
    .Cin     (cin8),
    .Sum     (sum8),
    .Cout    (cout8),
    .Sum_r   (sum8_r),
    .Cout_r  (cout8_r),
    .Ovf_r   (ovf8_r),
    .valid_r (valid8_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({sum1_r, cout1_r, ovf1_r, valid1_r} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_w1 regs: got %b need 0000", {sum1_r, cout1_r, ovf1_r, valid1_r});
    end
    n_checks++;
    if ({sum8_r, cout8_r, ovf8_r, valid8_r} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_w8 regs: got %h need 000", {sum8_r, cout8_r, ovf8_r, valid8_r});
    end
    n_checks++;
    if ({sum1, cout1} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_comb_w1: got %b need 01", {sum1, cout1});
    end
    n_checks++;
    if ({cout8, sum8} !== 9'h010) begin
      n_fail++;
      $display("FAIL reset_comb_w8: got %h need 010", {cout8, sum8});
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_tt [8];
    logic [2:0] vec;
    exp_tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      vec = i[2:0];
      {a1, b1, cin1} = vec;
      #5;
      n_checks++;
      if ({sum1, cout1} !== exp_tt[i]) begin
        n_fail++;
        $display("FAIL truth_table abc=%b: got sum,cout=%b need %b", vec, {sum1, cout1}, exp_tt[i]);
      end
      #5;
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({sum1_r, cout1_r, valid1_r, ovf1_r} !== 4'b1110) begin
      n_fail++;
      $display("FAIL latency_load: got sum_r,cout_r,valid_r,ovf_r=%b need 1110", {sum1_r, cout1_r, valid1_r, ovf1_r});
    end
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #1;
    n_checks++;
    if ({sum1, sum1_r} !== 2'b01) begin
      n_fail++;
      $display("FAIL latency_hold: got sum,sum_r=%b need 01", {sum1, sum1_r});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({sum1_r, cout1_r} !== 2'b00) begin
      n_fail++;
      $display("FAIL latency_next: got sum_r,cout_r=%b need 00", {sum1_r, cout1_r});
    end
  endtask

  task automatic test_sync_reset();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({sum1_r, cout1_r, valid1_r} !== 3'b011) begin
      n_fail++;
      $display("FAIL sreset_preload: got sum_r,cout_r,valid_r=%b need 011", {sum1_r, cout1_r, valid1_r});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sum1_r, cout1_r, valid1_r, sum1, cout1} !== 5'b01101) begin
      n_fail++;
      $display("FAIL sreset_midcycle: got sum_r,cout_r,valid_r,sum,cout=%b need 01101", {sum1_r, cout1_r, valid1_r, sum1, cout1});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({sum1_r, cout1_r, ovf1_r, valid1_r, sum1, cout1} !== 6'b000001) begin
      n_fail++;
      $display("FAIL sreset_edge: got sum_r,cout_r,ovf_r,valid_r,sum,cout=%b need 000001", {sum1_r, cout1_r, ovf1_r, valid1_r, sum1, cout1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({cout1_r, valid1_r} !== 2'b00) begin
      n_fail++;
      $display("FAIL sreset_release_early: got cout_r,valid_r=%b need 00", {cout1_r, valid1_r});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({sum1_r, cout1_r, valid1_r} !== 3'b011) begin
      n_fail++;
      $display("FAIL sreset_release: got sum_r,cout_r,valid_r=%b need 011", {sum1_r, cout1_r, valid1_r});
    end
  endtask

  task automatic test_w8_directed();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vc [5];
    logic [8:0] exp_cs [5];
    logic       exp_ovf [5];
    va      = '{8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h10};
    vb      = '{8'hFF, 8'h01, 8'h01, 8'h80, 8'h20};
    vc      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_cs  = '{9'h1FF, 9'h100, 9'h080, 9'h100, 9'h030};
    exp_ovf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = va[i]; b8 = vb[i]; cin8 = vc[i];
      #1;
      n_checks++;
      if ({cout8, sum8} !== exp_cs[i]) begin
        n_fail++;
        $display("FAIL w8_comb %h+%h+%b: got cout,sum=%h need %h", va[i], vb[i], vc[i], {cout8, sum8}, exp_cs[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({cout8_r, sum8_r, ovf8_r, valid8_r} !== {exp_cs[i], exp_ovf[i], 1'b1}) begin
        n_fail++;
        $display("FAIL w8_reg %h+%h+%b: got cout_r,sum_r,ovf_r,valid_r=%h need %h", va[i], vb[i], vc[i],
                 {cout8_r, sum8_r, ovf8_r, valid8_r}, {exp_cs[i], exp_ovf[i], 1'b1});
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] ref_cs, prev_cs;
    logic       prev_ovf;
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    prev_cs  = 9'h000;
    prev_ovf = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n_checks++;
      if ({cout8_r, sum8_r, ovf8_r} !== {prev_cs, prev_ovf}) begin
        n_fail++;
        $display("FAIL random_reg iter %0d: got cout_r,sum_r,ovf_r=%h need %h", i, {cout8_r, sum8_r, ovf8_r}, {prev_cs, prev_ovf});
      end
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      ref_cs = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
      #1;
      n_checks++;
      if ({cout8, sum8} !== ref_cs) begin
        n_fail++;
        $display("FAIL random_comb %h+%h+%b: got %h need %h", a8, b8, cin8, {cout8, sum8}, ref_cs);
      end
      prev_cs  = ref_cs;
      prev_ovf = (a8[7] == b8[7]) && (ref_cs[7] != a8[7]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    test_reset();
    test_truth_table();
    test_latency();
    test_sync_reset();
    test_w8_directed();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
